// File: rtl/d_ext_alu_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : d_ext_alu_pkg
//  Description : Shared types and constants for the D-extension ALU
//                writeback stage (result kinds, flag positions, FIFO entry).
//  Revision    : 1.0 - initial release
// ============================================================================
package d_ext_alu_pkg;

    // Data width carried in a FIFO entry.
    localparam int ENTRY_DATA_W = 64;

    // Destination class of an ALU result.
    typedef enum logic [1:0] {
        RK_FP64 = 2'd0,
        RK_FP32 = 2'd1,
        RK_INT  = 2'd2,
        RK_NONE = 2'd3
    } res_kind_e;

    // Exception flag bit positions inside a 5-bit fflags vector.
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Upper word used to NaN-box a single-precision value in a 64-bit register.
    localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

    // One buffered writeback entry.
    typedef struct packed {
        res_kind_e                 kind;
        logic [4:0]                rd;
        logic [ENTRY_DATA_W-1:0]   data;
        logic [4:0]                fflags;
    } wb_entry_t;

endpackage : d_ext_alu_pkg
`default_nettype wire

// File: rtl/d_ext_alu_wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : d_ext_alu_wb_stage_if
//  Description : ALU-to-writeback result bus with valid/ready handshake.
//                master = ALU side, slave = writeback stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface d_ext_alu_wb_stage_if #(
    parameter int XLEN = 64
);
    import d_ext_alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    res_kind_e         res_kind;
    logic [4:0]        rd;
    logic [XLEN-1:0]   result;
    logic [31:0]       fs_result;
    logic [XLEN-1:0]   int_result;
    logic [4:0]        in_fflags;

    modport master (
        output in_valid, res_kind, rd, result, fs_result, int_result, in_fflags,
        input  in_ready
    );

    modport slave (
        input  in_valid, res_kind, rd, result, fs_result, int_result, in_fflags,
        output in_ready
    );

endinterface : d_ext_alu_wb_stage_if
`default_nettype wire

// File: rtl/d_ext_alu_wb_stage_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : d_ext_wb_fifo
//  Description : DEPTH-entry synchronous FIFO of wb_entry_t with push, pop,
//                flush and occupancy count. Caller must not push when full
//                or pop when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_ext_wb_fifo
    import d_ext_alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       i_push,
    input  wire wb_entry_t                  i_push_data,
    input  wire logic                       i_pop,
    input  wire logic                       i_flush,
    output wb_entry_t                       o_head,
    output logic                            o_head_valid,
    output logic [$clog2(DEPTH):0]          o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    wb_entry_t          r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;

    // Pointer and count maintenance; flush returns everything to the empty state.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (rst_n && !i_flush && i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head       = r_mem[r_rd_ptr];
    assign o_head_valid = (r_count != '0);
    assign o_count      = r_count;

endmodule : d_ext_wb_fifo
`default_nettype wire

// File: rtl/d_ext_alu_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : d_ext_alu_wb_stage
//  Description : Writeback stage behind the D-extension ALU. Buffers results,
//                NaN-boxes single-precision values, drives FP / integer
//                register-file write ports and accrues sticky fflags.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_ext_alu_wb_stage
    import d_ext_alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    d_ext_alu_wb_stage_if.slave         alu,
    input  wire logic                   flush,
    input  wire logic                   wb_stall,
    output logic                        fp_wr_en,
    output logic [4:0]                  fp_wr_addr,
    output logic [XLEN-1:0]             fp_wr_data,
    output logic                        int_wr_en,
    output logic [4:0]                  int_wr_addr,
    output logic [XLEN-1:0]             int_wr_data,
    input  wire logic                   fflags_clr,
    output logic [4:0]                  fflags_acc,
    output logic [$clog2(DEPTH):0]      pending
);

    localparam int                      c_CW        = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0]         c_DEPTH_CNT = c_CW'(DEPTH);

    wb_entry_t          w_push_entry;
    wb_entry_t          w_head;
    logic               w_head_valid;
    logic               w_push;
    logic               w_head_go;
    logic               w_accrue;
    logic [c_CW-1:0]    w_count;
    logic [4:0]         r_fflags_acc;

    // Space is judged on registered occupancy only, so a full FIFO never
    // accepts in the same cycle its head retires.
    assign alu.in_ready = (w_count < c_DEPTH_CNT);
    assign w_push       = alu.in_valid && alu.in_ready && !flush;

    // Retire the head whenever the ports are free; reset and flush block it.
    assign w_head_go    = rst_n && w_head_valid && !wb_stall && !flush;
    assign w_accrue     = w_head_go && (w_head.kind != RK_NONE);

    // Format the data field at push time so the head drives the ports directly.
    always_comb begin
        w_push_entry        = '0;
        w_push_entry.kind   = alu.res_kind;
        w_push_entry.rd     = alu.rd;
        w_push_entry.fflags = alu.in_fflags;
        case (alu.res_kind)
            RK_FP64: w_push_entry.data = alu.result;
            RK_FP32: w_push_entry.data = {NANBOX_HI, alu.fs_result};
            RK_INT:  w_push_entry.data = alu.int_result;
            default: w_push_entry.data = '0;
        endcase
    end

    d_ext_wb_fifo #(
        .DEPTH        (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_data  (w_push_entry),
        .i_pop        (w_head_go),
        .i_flush      (flush),
        .o_head       (w_head),
        .o_head_valid (w_head_valid),
        .o_count      (w_count)
    );

    // Decode the retiring head into at most one register-file write.
    // An integer write to x0 is dropped but the entry still retires.
    always_comb begin
        fp_wr_en    = 1'b0;
        fp_wr_addr  = '0;
        fp_wr_data  = '0;
        int_wr_en   = 1'b0;
        int_wr_addr = '0;
        int_wr_data = '0;
        if (w_head_go) begin
            case (w_head.kind)
                RK_FP64, RK_FP32: begin
                    fp_wr_en   = 1'b1;
                    fp_wr_addr = w_head.rd;
                    fp_wr_data = w_head.data;
                end
                RK_INT: begin
                    if (w_head.rd != 5'd0) begin
                        int_wr_en   = 1'b1;
                        int_wr_addr = w_head.rd;
                        int_wr_data = w_head.data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky flag accrual; a clear in a retiring cycle keeps only the new flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fflags_acc <= '0;
        end else if (fflags_clr) begin
            r_fflags_acc <= w_accrue ? w_head.fflags : 5'b0;
        end else if (w_accrue) begin
            r_fflags_acc <= r_fflags_acc | w_head.fflags;
        end
    end

    assign fflags_acc = r_fflags_acc;
    assign pending    = w_count;

endmodule : d_ext_alu_wb_stage
`default_nettype wire

// File: tb/tb_d_ext_alu_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_ext_alu_wb_stage
//  Description : Directed self-checking bench for d_ext_alu_wb_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_d_ext_alu_wb_stage;
    import d_ext_alu_pkg::*;

    localparam int DEPTH = 2;
    localparam int XLEN  = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        wb_stall;
    logic        fflags_clr;
    logic        fp_wr_en;
    logic [4:0]  fp_wr_addr;
    logic [63:0] fp_wr_data;
    logic        int_wr_en;
    logic [4:0]  int_wr_addr;
    logic [63:0] int_wr_data;
    logic [4:0]  fflags_acc;
    logic [1:0]  pending;

    int n_tests = 0;
    int n_fail  = 0;

    d_ext_alu_wb_stage_if #(.XLEN(XLEN)) alu_if ();

    d_ext_alu_wb_stage #(
        .DEPTH       (DEPTH),
        .XLEN        (XLEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu         (alu_if.slave),
        .flush       (flush),
        .wb_stall    (wb_stall),
        .fp_wr_en    (fp_wr_en),
        .fp_wr_addr  (fp_wr_addr),
        .fp_wr_data  (fp_wr_data),
        .int_wr_en   (int_wr_en),
        .int_wr_addr (int_wr_addr),
        .int_wr_data (int_wr_data),
        .fflags_clr  (fflags_clr),
        .fflags_acc  (fflags_acc),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        alu_if.in_valid   = 1'b0;
        alu_if.res_kind   = RK_NONE;
        alu_if.rd         = 5'd0;
        alu_if.result     = 64'd0;
        alu_if.fs_result  = 32'd0;
        alu_if.int_result = 64'd0;
        alu_if.in_fflags  = 5'd0;
    endtask

    task automatic drive(input res_kind_e k, input logic [4:0] r, input logic [63:0] d64,
                         input logic [31:0] d32, input logic [63:0] di, input logic [4:0] f);
        alu_if.in_valid   = 1'b1;
        alu_if.res_kind   = k;
        alu_if.rd         = r;
        alu_if.result     = d64;
        alu_if.fs_result  = d32;
        alu_if.int_result = di;
        alu_if.in_fflags  = f;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; wb_stall = 1'b0; fflags_clr = 1'b0;
        clr_inputs();
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1; #1;
        n_tests++; if (pending !== 2'd0) begin n_fail++; $display("FAIL reset_pending: got %0d expected 0", pending); end
        n_tests++; if (alu_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", alu_if.in_ready); end
        n_tests++; if (fflags_acc !== 5'd0) begin n_fail++; $display("FAIL reset_fflags: got %b expected 00000", fflags_acc); end
        n_tests++; if ({fp_wr_en, int_wr_en, fp_wr_addr, int_wr_addr} !== 12'd0 || fp_wr_data !== 64'd0 || int_wr_data !== 64'd0) begin
            n_fail++; $display("FAIL reset_ports: fp_en=%b int_en=%b fp_data=%h int_data=%h expected all 0", fp_wr_en, int_wr_en, fp_wr_data, int_wr_data); end
    endtask

    task automatic test_fp32_nanbox();
        drive(RK_FP32, 5'd3, 64'd0, 32'h3F80_0000, 64'd0, 5'd0);
        next_cycle(); clr_inputs(); #1;
        n_tests++; if (fp_wr_en !== 1'b1 || fp_wr_addr !== 5'd3) begin n_fail++; $display("FAIL fp32_en_addr: got en=%b addr=%0d expected en=1 addr=3", fp_wr_en, fp_wr_addr); end
        n_tests++; if (fp_wr_data !== 64'hFFFF_FFFF_3F80_0000) begin n_fail++; $display("FAIL fp32_data: got %h expected ffffffff3f800000", fp_wr_data); end
        n_tests++; if (int_wr_en !== 1'b0 || pending !== 2'd1) begin n_fail++; $display("FAIL fp32_side: got int_en=%b pending=%0d expected 0/1", int_wr_en, pending); end
        next_cycle(); #1;
        n_tests++; if (pending !== 2'd0 || fp_wr_en !== 1'b0) begin n_fail++; $display("FAIL fp32_retire: got pending=%0d en=%b expected 0/0", pending, fp_wr_en); end
    endtask

    task automatic test_int_rd0();
        drive(RK_INT, 5'd0, 64'd0, 32'd0, 64'h1234, 5'b00001);
        next_cycle(); clr_inputs(); #1;
        n_tests++; if (int_wr_en !== 1'b0 || fp_wr_en !== 1'b0 || int_wr_data !== 64'd0) begin
            n_fail++; $display("FAIL int_rd0_suppress: got int_en=%b fp_en=%b data=%h expected 0/0/0", int_wr_en, fp_wr_en, int_wr_data); end
        n_tests++; if (pending !== 2'd1) begin n_fail++; $display("FAIL int_rd0_head: got pending=%0d expected 1", pending); end
        next_cycle(); #1;
        n_tests++; if (pending !== 2'd0) begin n_fail++; $display("FAIL int_rd0_retire: got pending=%0d expected 0", pending); end
        n_tests++; if (fflags_acc !== 5'b00001) begin n_fail++; $display("FAIL int_rd0_fflags: got %b expected 00001", fflags_acc); end
    endtask

    task automatic test_int_write();
        drive(RK_INT, 5'd5, 64'hFFFF_0000_FFFF_0000, 32'hDEAD_0000, 64'hDEAD_BEEF_0000_0042, 5'd0);
        next_cycle(); clr_inputs(); #1;
        n_tests++; if (int_wr_en !== 1'b1 || int_wr_addr !== 5'd5 || int_wr_data !== 64'hDEAD_BEEF_0000_0042) begin
            n_fail++; $display("FAIL int_write: got en=%b addr=%0d data=%h expected 1/5/deadbeef00000042", int_wr_en, int_wr_addr, int_wr_data); end
        n_tests++; if (fp_wr_en !== 1'b0 || fp_wr_data !== 64'd0) begin n_fail++; $display("FAIL int_write_fp_idle: got en=%b data=%h expected 0/0", fp_wr_en, fp_wr_data); end
        next_cycle(); #1;
    endtask

    task automatic test_stall_full();
        wb_stall = 1'b1;
        drive(RK_FP64, 5'd1, 64'hAAAA_0000_0000_0001, 32'd0, 64'd0, 5'd0);
        next_cycle();
        drive(RK_FP64, 5'd2, 64'hBBBB_0000_0000_0002, 32'd0, 64'd0, 5'd0); #1;
        n_tests++; if (pending !== 2'd1 || alu_if.in_ready !== 1'b1 || fp_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL stall_one: got pending=%0d ready=%b en=%b expected 1/1/0", pending, alu_if.in_ready, fp_wr_en); end
        next_cycle();
        drive(RK_FP64, 5'd3, 64'hCCCC_0000_0000_0003, 32'd0, 64'd0, 5'd0); #1;
        n_tests++; if (pending !== 2'd2 || alu_if.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_full: got pending=%0d ready=%b expected 2/0", pending, alu_if.in_ready); end
        next_cycle(); #1;
        n_tests++; if (pending !== 2'd2 || alu_if.in_ready !== 1'b0 || fp_wr_en !== 1'b0 || fp_wr_data !== 64'd0) begin
            n_fail++; $display("FAIL stall_hold: got pending=%0d ready=%b en=%b data=%h expected 2/0/0/0", pending, alu_if.in_ready, fp_wr_en, fp_wr_data); end
        wb_stall = 1'b0; #1;
        n_tests++; if (fp_wr_en !== 1'b1 || fp_wr_addr !== 5'd1 || fp_wr_data !== 64'hAAAA_0000_0000_0001) begin
            n_fail++; $display("FAIL stall_release_a: got en=%b addr=%0d data=%h expected 1/1/aaaa000000000001", fp_wr_en, fp_wr_addr, fp_wr_data); end
        next_cycle(); #1;
        n_tests++; if (pending !== 2'd1 || alu_if.in_ready !== 1'b1 || fp_wr_addr !== 5'd2 || fp_wr_data !== 64'hBBBB_0000_0000_0002) begin
            n_fail++; $display("FAIL stall_release_b: got pending=%0d ready=%b addr=%0d data=%h expected 1/1/2/bbbb000000000002", pending, alu_if.in_ready, fp_wr_addr, fp_wr_data); end
        next_cycle(); clr_inputs(); #1;
        n_tests++; if (pending !== 2'd1 || fp_wr_en !== 1'b1 || fp_wr_addr !== 5'd3 || fp_wr_data !== 64'hCCCC_0000_0000_0003) begin
            n_fail++; $display("FAIL stall_release_c: got pending=%0d en=%b addr=%0d data=%h expected 1/1/3/cccc000000000003", pending, fp_wr_en, fp_wr_addr, fp_wr_data); end
        next_cycle(); #1;
        n_tests++; if (pending !== 2'd0) begin n_fail++; $display("FAIL stall_drain: got pending=%0d expected 0", pending); end
    endtask

    task automatic test_flush();
        wb_stall = 1'b1;
        drive(RK_FP64, 5'd7, 64'h1111, 32'd0, 64'd0, 5'b10000);
        next_cycle();
        drive(RK_FP32, 5'd8, 64'd0, 32'h2222, 64'd0, 5'b00100);
        next_cycle(); clr_inputs(); #1;
        n_tests++; if (pending !== 2'd2) begin n_fail++; $display("FAIL flush_setup: got pending=%0d expected 2", pending); end
        wb_stall = 1'b0; flush = 1'b1; #1;
        n_tests++; if (fp_wr_en !== 1'b0 || int_wr_en !== 1'b0 || fp_wr_data !== 64'd0) begin
            n_fail++; $display("FAIL flush_no_write: got fp_en=%b int_en=%b data=%h expected 0/0/0", fp_wr_en, int_wr_en, fp_wr_data); end
        next_cycle(); flush = 1'b0; #1;
        n_tests++; if (pending !== 2'd0 || alu_if.in_ready !== 1'b1 || fp_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty: got pending=%0d ready=%b en=%b expected 0/1/0", pending, alu_if.in_ready, fp_wr_en); end
        n_tests++; if (fflags_acc !== 5'b00001) begin n_fail++; $display("FAIL flush_fflags: got %b expected 00001", fflags_acc); end
    endtask

    task automatic test_fflags();
        fflags_clr = 1'b1;
        next_cycle(); fflags_clr = 1'b0; #1;
        n_tests++; if (fflags_acc !== 5'd0) begin n_fail++; $display("FAIL fflags_clear: got %b expected 00000", fflags_acc); end
        drive(RK_FP64, 5'd4, 64'h4, 32'd0, 64'd0, 5'b10000);
        next_cycle(); clr_inputs();
        next_cycle(); #1;
        n_tests++; if (fflags_acc !== 5'b10000) begin n_fail++; $display("FAIL fflags_nv: got %b expected 10000", fflags_acc); end
        drive(RK_FP64, 5'd5, 64'h5, 32'd0, 64'd0, 5'b01000);
        next_cycle(); clr_inputs(); fflags_clr = 1'b1; #1;
        n_tests++; if (fp_wr_en !== 1'b1 || fp_wr_addr !== 5'd5) begin n_fail++; $display("FAIL fflags_dz_write: got en=%b addr=%0d expected 1/5", fp_wr_en, fp_wr_addr); end
        next_cycle(); fflags_clr = 1'b0; #1;
        n_tests++; if (fflags_acc !== 5'b01000) begin n_fail++; $display("FAIL fflags_clr_retire: got %b expected 01000", fflags_acc); end
        drive(RK_NONE, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'b11111);
        next_cycle(); clr_inputs(); #1;
        n_tests++; if (fp_wr_en !== 1'b0 || int_wr_en !== 1'b0 || pending !== 2'd1 || fp_wr_data !== 64'd0) begin
            n_fail++; $display("FAIL none_no_write: got fp_en=%b int_en=%b pending=%0d data=%h expected 0/0/1/0", fp_wr_en, int_wr_en, pending, fp_wr_data); end
        next_cycle(); #1;
        n_tests++; if (pending !== 2'd0 || fflags_acc !== 5'b01000) begin
            n_fail++; $display("FAIL none_no_accrue: got pending=%0d fflags=%b expected 0/01000", pending, fflags_acc); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) drive(RK_INT, 5'(10 + k), 64'd0, 32'd0, 64'h100 + 64'(k), 5'd0);
            else clr_inputs();
            #1;
            if (k > 0) begin
                n_tests++;
                if (int_wr_en !== 1'b1 || int_wr_addr !== 5'(9 + k) || int_wr_data !== 64'h0FF + 64'(k) || pending !== 2'd1) begin
                    n_fail++; $display("FAIL b2b_%0d: got en=%b addr=%0d data=%h pending=%0d expected 1/%0d/%h/1",
                                       k, int_wr_en, int_wr_addr, int_wr_data, pending, 9 + k, 64'h0FF + 64'(k)); end
            end
            next_cycle();
        end
        #1;
        n_tests++; if (pending !== 2'd0 || int_wr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got pending=%0d en=%b expected 0/0", pending, int_wr_en); end
    endtask

    task automatic test_reset_mid();
        wb_stall = 1'b1;
        drive(RK_FP64, 5'd9, 64'h9999, 32'd0, 64'd0, 5'b00010);
        next_cycle();
        drive(RK_INT, 5'd12, 64'd0, 32'd0, 64'h7777, 5'b00001);
        next_cycle(); clr_inputs(); #1;
        n_tests++; if (pending !== 2'd2) begin n_fail++; $display("FAIL rstmid_setup: got pending=%0d expected 2", pending); end
        rst_n = 1'b0; wb_stall = 1'b0; #1;
        n_tests++; if (fp_wr_en !== 1'b0 || int_wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_during: got fp_en=%b int_en=%b expected 0/0", fp_wr_en, int_wr_en); end
        next_cycle(); rst_n = 1'b1; #1;
        n_tests++; if (pending !== 2'd0 || alu_if.in_ready !== 1'b1 || fflags_acc !== 5'd0) begin
            n_fail++; $display("FAIL rstmid_state: got pending=%0d ready=%b fflags=%b expected 0/1/00000", pending, alu_if.in_ready, fflags_acc); end
        n_tests++; if (fp_wr_en !== 1'b0 || int_wr_en !== 1'b0 || fp_wr_addr !== 5'd0 || fp_wr_data !== 64'd0 || int_wr_data !== 64'd0) begin
            n_fail++; $display("FAIL rstmid_ports: got fp_en=%b int_en=%b fp_data=%h int_data=%h expected all 0", fp_wr_en, int_wr_en, fp_wr_data, int_wr_data); end
        next_cycle(); #1;
        n_tests++; if (fp_wr_en !== 1'b0 || int_wr_en !== 1'b0 || pending !== 2'd0) begin
            n_fail++; $display("FAIL rstmid_after: got fp_en=%b int_en=%b pending=%0d expected 0/0/0", fp_wr_en, int_wr_en, pending); end
    endtask

    initial begin
        test_reset();
        test_fp32_nanbox();
        test_int_rd0();
        test_int_write();
        test_stall_full();
        test_flush();
        test_fflags();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_d_ext_alu_wb_stage
`default_nettype wire

// File: doc/d_ext_alu_wb_stage.md
Name: d_ext_alu_wb_stage

Overview:
- Writeback stage directly downstream of the D-extension ALU.
- Captures the ALU's three result buses (result, fs_result, int_result) plus destination info into a small FIFO.
- Selects and formats the result: NaN-boxes single-precision values, and drives the FP and integer register-file write ports under a stall signal.
- Accrues exception flags into a sticky fflags register.

Parameters:
DEPTH, 2, number of FIFO entries (power of 2, >=2)
XLEN, 64, register and data width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  ALU result valid
in_ready  output  1  stage can accept a result
res_kind  input  2  destination class (see package)
rd  input  5  destination register index
result  input  64  double-precision result from ALU
fs_result  input  32  single-precision result from ALU
int_result  input  64  integer result from ALU
in_fflags  input  5  NV,DZ,OF,UF,NX from this operation
flush  input  1  discard all buffered entries
wb_stall  input  1  register-file write ports busy this cycle
fp_wr_en  output  1  FP register-file write enable
fp_wr_addr  output  5  FP write index
fp_wr_data  output  64  FP write data
int_wr_en  output  1  integer register-file write enable
int_wr_addr  output  5  integer write index
int_wr_data  output  64  integer write data
fflags_clr  input  1  clear accrued flags
fflags_acc  output  5  sticky accrued flags
pending  output  $clog2(DEPTH)+1  occupied entry count

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n), sampled at the rising edge.
- Reset state:
  - FIFO empty; pending=0; fflags_acc=0.
  - All write enables, addresses and data read 0.
  - in_ready=1 from the first cycle after reset release.
- Push:
  - Occurs when in_valid && in_ready && !flush.
  - The entry stores kind, rd, fflags, and a 64-bit data field selected at push:
    - FP64: result.
    - FP32: {32'hFFFF_FFFF, fs_result} (NaN-box).
    - INT: int_result.
    - NONE: 0.
- in_ready = (pending < DEPTH). It depends on registered state only; there is no same-cycle pass-through when full.
- Head write:
  - Driven combinationally from the head entry when head valid && !wb_stall && !flush.
  - FP64/FP32 → fp_wr_en=1.
  - INT → int_wr_en=1, except when rd==0: write suppressed, entry still retires.
  - NONE → no enable, entry retires.
  - At most one enable is high per cycle.
  - When no write occurs, address and data outputs read 0.
- Pop: the head retires at the same edge as its write, i.e. any cycle with head valid && !wb_stall && !flush.
- Latency: a result accepted at edge N is visible on the write port in cycle N+1 (throughput 1/cycle when unstalled).
- Simultaneous push and pop: pending unchanged and order preserved. Pointers wrap modulo DEPTH.
- Stall: head held, outputs 0, push continues until full.
- Flush:
  - Takes priority over push and pop; no write enable is asserted in a flush cycle.
  - Next cycle: pending=0 and pointers reset.
- fflags:
  - On each retiring entry of kind FP64/FP32/INT, fflags_acc |= entry fflags. NONE entries and flushed entries never accrue.
  - fflags_clr with a same-cycle retire: fflags_acc <= retiring flags only.
  - fflags_clr alone: fflags_acc <= 0.
- Reset mid-operation: buffered entries are discarded and nothing is written.

Decomposition:
- Package d_ext_alu_pkg:
  - res_kind_e: RK_FP64=0, RK_FP32=1, RK_INT=2, RK_NONE=3.
  - Flag bit positions.
  - NANBOX_HI = 32'hFFFF_FFFF.
  - wb_entry_t struct: kind, rd, data, fflags.
- One sub-module, d_ext_wb_fifo: a generic DEPTH-entry synchronous FIFO of wb_entry_t with push/pop/flush/count. The top holds the format mux, write decode and fflags logic.

Test Plan:
1. Push FP32 fs_result=32'h3F80_0000, rd=3, no stall → next cycle fp_wr_en=1, addr=3, data=64'hFFFF_FFFF_3F80_0000; pending returns to 0.
2. Push INT int_result=64'h1234, rd=0, in_fflags=5'b00001 → int_wr_en stays 0, entry retires, fflags_acc=5'b00001.
3. wb_stall=1, push three FP64 results (DEPTH=2) → in_ready drops after 2 and pending=2. Release stall → writes occur in push order on consecutive cycles, and the third result is accepted once space frees.
4. Two entries buffered with flags NV and OF, assert flush → no write enables, pending=0 next cycle, fflags_acc unchanged.
5. fflags_acc=5'b10000, retire an entry with DZ (5'b01000) while fflags_clr=1 → fflags_acc=5'b01000.
6. Drive rst_n=0 for one cycle with pending=2 mid-stall → all outputs 0, pending=0, in_ready=1 after release, no writes.
